fetch_stage: RTL and testbench

- Instruction-fetch stage with IF/ID pipeline register; directly upstream of the decode logic and immediate generator.
- Holds the PC, issues one-outstanding-request fetches to instruction memory, and presents a 32-bit instruction plus its PC to decode through a valid/ready handshake.
- Accepts branch redirects from execute and discards stale responses.

---
 rtl/fetch_stage_if.sv | 31 +++
 rtl/fetch_stage.sv | 121 ++++++++++++
 tb/tb_fetch_stage.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, execute redirect,
// and the IF/ID handshake toward decode.
interface fetch_stage_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        id_ready;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_target,
        output id_valid, id_inst, id_pc,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_target,
        input  id_valid, id_inst, id_pc,
        output id_ready
    );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register, one outstanding imem request and a one-entry skid buffer.
// Optional sticky misaligned-redirect flag: define FETCH_MISALIGN_CHECK_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus,
    output logic          misalign_err
);

    typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD, S_DROP} state_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } slot_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    slot_t       id_q, id_d;
    slot_t       buf_q, buf_d;
    logic        id_vld_q, id_vld_d;
    logic        slot_free;
    logic [31:0] redir_pc;

    assign redir_pc  = bus.redirect_target & 32'hFFFF_FFFC;
    assign slot_free = ~id_vld_q | bus.id_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            id_q     <= '{inst: NOP_INST, pc: 32'h0};
            buf_q    <= '{inst: NOP_INST, pc: 32'h0};
            id_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            id_q     <= id_d;
            buf_q    <= buf_d;
            id_vld_q <= id_vld_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        id_d     = id_q;
        buf_d    = buf_q;
        id_vld_d = id_vld_q;

        if (id_vld_q && bus.id_ready)
            id_vld_d = 1'b0;

        if (bus.redirect_valid) begin
            pc_d         = redir_pc;
            id_vld_d     = 1'b0;
            id_d.inst    = NOP_INST;
            // A response landing with the redirect is the one we were waiting for;
            // swallowing it here means nothing is outstanding, so fetch resumes directly.
            unique case (state_q)
                S_FETCH: state_d = bus.imem_req_ready ? S_DROP : S_FETCH;
                S_WAIT:  state_d = bus.imem_rsp_valid ? S_FETCH : S_DROP;
                S_DROP:  state_d = bus.imem_rsp_valid ? S_FETCH : S_DROP;
                S_HOLD:  state_d = S_FETCH;
            endcase
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (bus.imem_req_ready)
                        state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        if (slot_free) begin
                            id_d     = '{inst: bus.imem_rsp_data, pc: pc_q};
                            id_vld_d = 1'b1;
                            pc_d     = pc_q + 32'd4;
                            state_d  = S_FETCH;
                        end else begin
                            buf_d   = '{inst: bus.imem_rsp_data, pc: pc_q};
                            state_d = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.id_ready) begin
                        id_d     = buf_q;
                        id_vld_d = 1'b1;
                        pc_d     = pc_q + 32'd4;
                        state_d  = S_FETCH;
                    end
                end
                S_DROP: begin
                    if (bus.imem_rsp_valid)
                        state_d = S_FETCH;
                end
            endcase
        end
    end

    assign bus.imem_req_valid = (state_q == S_FETCH) && !reset;
    assign bus.imem_req_addr  = pc_q;
    assign bus.id_valid       = id_vld_q;
    assign bus.id_inst        = id_vld_q ? id_q.inst : NOP_INST;
    assign bus.id_pc          = id_q.pc;

`ifdef FETCH_MISALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset)
            misalign_err <= 1'b0;
        else if (bus.redirect_valid && bus.redirect_target[1:0] != 2'b00)
            misalign_err <= 1'b1;
    end
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed phases plus randomized memory latency, stalls, redirects and
// resets; a path-based scoreboard predicts every delivered instruction.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef FETCH_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic misalign_err;
  logic rst2;
  logic mis2;

  fetch_stage_if bus();
  fetch_stage_if bus2();

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
    .clk(clk), .reset(reset), .bus(bus), .misalign_err(misalign_err));

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) dut2 (
    .clk(clk), .reset(rst2), .bus(bus2), .misalign_err(mis2));

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int xfer_cnt = 0;
  int rdy_pct = 100;
  int lat_min = 1;
  int lat_max = 1;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic redirect(input logic [31:0] t);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = t;
    exp_q.delete();
    exp_q.push_back(t & 32'hFFFF_FFFC);
    step();
    bus.redirect_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    exp_q.delete();
    exp_q.push_back(32'h0);
    repeat (n) step();
    reset = 1'b0;
  endtask

  // Bounded waits, called from a negedge sample point.
  task automatic wait_accept(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.imem_req_valid && bus.imem_req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_reqv(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.imem_req_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_valid(input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.id_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check(name, 32'(ok), 32'd1);
  endtask

  // Instruction memory: random ready, one response 'lat' cycles after acceptance.
  initial begin
    bit acc_seen;
    bit pend;
    int cnt;
    logic [31:0] acc_addr;
    logic [31:0] pend_addr;
    acc_seen = 1'b0; pend = 1'b0; cnt = 0; acc_addr = '0; pend_addr = '0;
    bus.imem_req_ready = 1'b0;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pend = 1'b0; acc_seen = 1'b0;
      end else if (bus.imem_req_valid && bus.imem_req_ready) begin
        acc_seen = 1'b1;
        acc_addr = bus.imem_req_addr;
        check("req_align", 32'(bus.imem_req_addr[1:0]), 32'd0);
      end
      @(posedge clk); #1;
      bus.imem_rsp_valid = 1'b0;
      if (acc_seen) begin
        check("one_outstanding", 32'(pend), 32'd0);
        pend = 1'b1; pend_addr = acc_addr; acc_seen = 1'b0;
        cnt = $urandom_range(lat_max, lat_min);
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          bus.imem_rsp_valid = 1'b1;
          bus.imem_rsp_data  = memf(pend_addr);
          pend = 1'b0;
        end
      end
      bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
    end
  end

  // Monitor / scoreboard: the delivered stream must be consecutive PCs from the last path start.
  initial begin
    bit exp_mis, prev_stall, prev_redir;
    logic [31:0] prev_inst, prev_pc, e;
    exp_mis = 1'b0; prev_stall = 1'b0; prev_redir = 1'b0; prev_inst = '0; prev_pc = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_mis = 1'b0; prev_stall = 1'b0; prev_redir = 1'b0;
      end else begin
        if (!bus.id_valid) check("nop_when_idle", bus.id_inst, NOP);
        if (prev_redir) check("flush_after_redirect", 32'(bus.id_valid), 32'd0);
        if (prev_stall) begin
          check("stall_valid", 32'(bus.id_valid), 32'd1);
          check("stall_inst", bus.id_inst, prev_inst);
          check("stall_pc", bus.id_pc, prev_pc);
        end
        check("misalign_err", 32'(misalign_err), 32'(exp_mis));
        if (bus.id_valid && bus.id_ready && !bus.redirect_valid) begin
          xfer_cnt++;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL sb_empty: got pc %h expected none", bus.id_pc);
          end else begin
            e = exp_q.pop_front();
            check("sb_pc", bus.id_pc, e);
            check("sb_inst", bus.id_inst, memf(e));
            exp_q.push_back(e + 32'd4);
          end
        end
        if (bus.redirect_valid && bus.redirect_target[1:0] != 2'b00 && MIS_EN) exp_mis = 1'b1;
        prev_redir = bus.redirect_valid;
        prev_stall = bus.id_valid && !bus.id_ready && !bus.redirect_valid;
        prev_inst  = bus.id_inst;
        prev_pc    = bus.id_pc;
      end
    end
  end

  // Second instance: zero-wait memory, checks the reset PC wrap.
  logic [31:0] addrs2[$];
  logic [31:0] first_pc2, first_inst2;
  bit first2 = 1'b1;
  initial begin
    bit a;
    logic [31:0] ad;
    first_pc2 = '0; first_inst2 = '0;
    bus2.imem_req_ready = 1'b1; bus2.imem_rsp_valid = 1'b0; bus2.imem_rsp_data = '0;
    bus2.redirect_valid = 1'b0; bus2.redirect_target = '0; bus2.id_ready = 1'b1;
    rst2 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst2 = 1'b0;
    forever begin
      @(negedge clk);
      a  = bus2.imem_req_valid && bus2.imem_req_ready;
      ad = bus2.imem_req_addr;
      if (a && addrs2.size() < 4) addrs2.push_back(ad);
      if (bus2.id_valid && first2) begin
        first2 = 1'b0; first_pc2 = bus2.id_pc; first_inst2 = bus2.id_inst;
      end
      @(posedge clk); #1;
      bus2.imem_rsp_valid = a;
      bus2.imem_rsp_data  = memf(ad);
    end
  end

  initial begin
    logic [31:0] t;
    reset = 1'b1;
    bus.id_ready = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_target = '0;
    exp_q.push_back(32'h0);

    // Reset values and first-fetch timing with zero-wait memory.
    #1; step();
    @(negedge clk);
    check("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("rst_id_valid", 32'(bus.id_valid), 32'd0);
    check("rst_id_inst", bus.id_inst, NOP);
    check("rst_id_pc", bus.id_pc, 32'h0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    step(); reset = 1'b0;
    @(negedge clk);
    check("c1_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("c1_req_addr", bus.imem_req_addr, 32'h0);
    check("c1_id_valid", 32'(bus.id_valid), 32'd0);
    step(); @(negedge clk);
    check("c2_req_valid", 32'(bus.imem_req_valid), 32'd0);
    check("c2_id_valid", 32'(bus.id_valid), 32'd0);
    step(); @(negedge clk);
    check("c3_id_valid", 32'(bus.id_valid), 32'd1);
    check("c3_id_pc", bus.id_pc, 32'h0);
    for (int k = 1; k <= 2; k++) begin
      step(); @(negedge clk);
      check("gap_id_valid", 32'(bus.id_valid), 32'd0);
      step(); @(negedge clk);
      check("seq_id_valid", 32'(bus.id_valid), 32'd1);
      check("seq_id_pc", bus.id_pc, 32'(k * 4));
    end

    // Reset in WAIT while the response arrives.
    step(); do_reset(1);
    bus.id_ready = 1'b0;
    @(negedge clk);
    check("rr_id_valid", 32'(bus.id_valid), 32'd0);
    check("rr_id_inst", bus.id_inst, NOP);
    check("rr_id_pc", bus.id_pc, 32'h0);
    check("rr_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("rr_req_addr", bus.imem_req_addr, 32'h0);

    // Stall: pc 0 held, pc 4 parked in the skid buffer.
    wait_valid("stall_first_valid");
    check("stall_first_pc", bus.id_pc, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step(); @(negedge clk);
      check("stall_hold_pc", bus.id_pc, 32'h0);
      check("stall_hold_inst", bus.id_inst, memf(32'h0));
      if (i >= 1) check("stall_no_req", 32'(bus.imem_req_valid), 32'd0);
    end
    step(); bus.id_ready = 1'b1;
    @(negedge clk);
    check("release_pc", bus.id_pc, 32'h0);
    step(); @(negedge clk);
    check("buf_valid", 32'(bus.id_valid), 32'd1);
    check("buf_pc", bus.id_pc, 32'h4);
    check("buf_next_req", 32'(bus.imem_req_valid), 32'd1);
    check("buf_next_addr", bus.imem_req_addr, 32'h8);

    // Redirect in WAIT, stale response two cycles later.
    lat_min = 3; lat_max = 3;
    wait_accept("t3_accept");
    step(); redirect(32'h100);
    @(negedge clk);
    check("t3_drop_req", 32'(bus.imem_req_valid), 32'd0);
    check("t3_drop_idv", 32'(bus.id_valid), 32'd0);
    step(); @(negedge clk);
    check("t3_drop_req2", 32'(bus.imem_req_valid), 32'd0);
    check("t3_drop_idv2", 32'(bus.id_valid), 32'd0);
    step(); @(negedge clk);
    check("t3_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("t3_req_addr", bus.imem_req_addr, 32'h100);
    wait_valid("t3_valid");
    check("t3_id_pc", bus.id_pc, 32'h100);

    // Redirect coinciding with the response.
    lat_min = 1; lat_max = 1;
    wait_accept("t4a_accept");
    step(); redirect(32'h200);
    @(negedge clk);
    wait_valid("t4a_valid");
    check("t4a_id_pc", bus.id_pc, 32'h200);

    // Redirect in the cycle FETCH is accepted.
    rdy_pct = 0;
    step(); @(negedge clk);
    wait_reqv("t4b_reqv");
    rdy_pct = 100; lat_min = 2; lat_max = 2;
    step(); redirect(32'h300);
    @(negedge clk);
    check("t4b_drop_req", 32'(bus.imem_req_valid), 32'd0);
    wait_valid("t4b_valid");
    check("t4b_id_pc", bus.id_pc, 32'h300);

    // Misaligned redirect while FETCH is held.
    rdy_pct = 0;
    step(); @(negedge clk);
    wait_reqv("t5_reqv");
    step(); redirect(32'h203);
    @(negedge clk);
    check("t5_req_valid", 32'(bus.imem_req_valid), 32'd1);
    check("t5_req_addr", bus.imem_req_addr, 32'h200);
    check("t5_misalign", 32'(misalign_err), 32'(MIS_EN));
    rdy_pct = 100; lat_min = 1;
    wait_valid("t5_valid");
    check("t5_id_pc", bus.id_pc, 32'h200);

    // Randomized traffic.
    rdy_pct = 70; lat_min = 1; lat_max = 3;
    xfer_cnt = 0;
    step();
    for (int c = 0; c < 3000; c++) begin
      bus.id_ready = ($urandom_range(99) < 70);
      if ($urandom_range(999) < 3) begin
        do_reset($urandom_range(2, 1));
      end else if ($urandom_range(99) < 3) begin
        case ($urandom_range(2))
          0: t = $urandom;
          1: t = 32'hFFFF_FFF0 | 32'($urandom_range(15));
          default: t = 32'($urandom_range(255));
        endcase
        redirect(t);
      end else begin
        step();
      end
    end
    bus.id_ready = 1'b1;
    repeat (10) step();
    check("liveness", 32'(xfer_cnt > 200), 32'd1);

    check("wrap_nreq", 32'(addrs2.size() >= 3), 32'd1);
    if (addrs2.size() >= 3) begin
      check("wrap_addr0", addrs2[0], 32'hFFFF_FFFC);
      check("wrap_addr1", addrs2[1], 32'h0);
      check("wrap_addr2", addrs2[2], 32'h4);
    end
    check("wrap_first_pc", first_pc2, 32'hFFFF_FFFC);
    check("wrap_first_inst", first_inst2, memf(32'hFFFF_FFFC));
    check("wrap_misalign", 32'(mis2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
